// File: rtl/otter_pkg.sv
// Shared OTTER pipeline definitions: opcodes and the
// decoder control bundle carried from ID into EX.
package otter_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef struct packed {
        logic       jump;
        logic       branch;
        logic       regWrite;
        logic       memWE2;
        logic       memRDEN2;
        logic [3:0] alu_fun;
        logic [1:0] alu_srca;
        logic [2:0] alu_srcb;
        logic [1:0] rf_wr_sel;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_pipe_hazard_unit.sv
// Load-use detection between the ID instruction and the
// load (if any) currently sitting in EX.
module hazard_unit
    import otter_pkg::*;
(
    input  logic       id_valid_i,
    input  logic [6:0] id_op_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       ex_valid_i,
    input  logic       ex_memRDEN2_i,
    input  logic       ex_memWE2_i,
    input  logic [4:0] ex_rd_i,
    output logic       stall_o
);

    logic use_rs1;
    logic use_rs2;
    logic ex_load;
    logic hit_rs1;
    logic hit_rs2;

    always_comb begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b0;
        unique case (id_op_i)
            OP_LUI, OP_AUIPC, OP_JAL: use_rs1 = 1'b0;
            OP_RTYPE, OP_STORE, OP_BRANCH: use_rs2 = 1'b1;
            default: ;
        endcase
    end

    // Stores raise RDEN2 too, so WE2 disqualifies them.
    assign ex_load = ex_valid_i & ex_memRDEN2_i & ~ex_memWE2_i;
    assign hit_rs1 = use_rs1 & (id_rs1_i == ex_rd_i);
    assign hit_rs2 = use_rs2 & (id_rs2_i == ex_rd_i);
    assign stall_o = id_valid_i & ex_load & (ex_rd_i != 5'd0)
                   & (hit_rs1 | hit_rs2);

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use bubble insertion,
// flush/hold control and saturating stall/flush counters.
module id_ex_pipe
    import otter_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             id_valid,
    input  logic [31:0]      id_ir,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic             id_jump,
    input  logic             id_branch,
    input  logic             id_regWrite,
    input  logic             id_memWE2,
    input  logic             id_memRDEN2,
    input  logic [3:0]       id_alu_fun,
    input  logic [1:0]       id_alu_srca,
    input  logic [2:0]       id_alu_srcb,
    input  logic [1:0]       id_rf_wr_sel,
    input  logic             flush,
    input  logic             hold,
    output logic             ex_valid,
    output logic [4:0]       ex_rd,
    output logic [31:0]      ex_ir,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic             ex_jump,
    output logic             ex_branch,
    output logic             ex_regWrite,
    output logic             ex_memWE2,
    output logic             ex_memRDEN2,
    output logic [3:0]       ex_alu_fun,
    output logic [1:0]       ex_alu_srca,
    output logic [2:0]       ex_alu_srcb,
    output logic [1:0]       ex_rf_wr_sel,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ctrl_t            id_ctrl;
    ctrl_t            ctrl_q, ctrl_d;
    logic             valid_q, valid_d;
    logic [4:0]       rd_q, rd_d;
    logic [31:0]      ir_q, ir_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  rs1_q, rs1_d;
    logic [XLEN-1:0]  rs2_q, rs2_d;
    logic [CNT_W-1:0] scnt_q, scnt_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;

    assign id_ctrl = '{
        jump:      id_jump,
        branch:    id_branch,
        regWrite:  id_regWrite,
        memWE2:    id_memWE2,
        memRDEN2:  id_memRDEN2,
        alu_fun:   id_alu_fun,
        alu_srca:  id_alu_srca,
        alu_srcb:  id_alu_srcb,
        rf_wr_sel: id_rf_wr_sel
    };

    hazard_unit u_hazard (
        .id_valid_i    (id_valid),
        .id_op_i       (id_ir[6:0]),
        .id_rs1_i      (id_ir[19:15]),
        .id_rs2_i      (id_ir[24:20]),
        .ex_valid_i    (valid_q),
        .ex_memRDEN2_i (ctrl_q.memRDEN2),
        .ex_memWE2_i   (ctrl_q.memWE2),
        .ex_rd_i       (rd_q),
        .stall_o       (stall)
    );

    always_comb begin
        valid_d = valid_q;
        rd_d    = rd_q;
        ir_d    = ir_q;
        pc_d    = pc_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        ctrl_d  = ctrl_q;
        if (flush || (!hold && stall)) begin
            valid_d = 1'b0;
            rd_d    = '0;
            ir_d    = '0;
            pc_d    = '0;
            rs1_d   = '0;
            rs2_d   = '0;
            ctrl_d  = CTRL_BUBBLE;
        end else if (!hold) begin
            valid_d = id_valid;
            rd_d    = id_ir[11:7];
            ir_d    = id_ir;
            pc_d    = id_pc;
            rs1_d   = id_rs1_data;
            rs2_d   = id_rs2_data;
            ctrl_d  = id_ctrl;
            // An empty slot must never write state downstream.
            if (!id_valid) begin
                ctrl_d.jump     = 1'b0;
                ctrl_d.branch   = 1'b0;
                ctrl_d.regWrite = 1'b0;
                ctrl_d.memWE2   = 1'b0;
                ctrl_d.memRDEN2 = 1'b0;
            end
        end
    end

    always_comb begin
        scnt_d = scnt_q;
        fcnt_d = fcnt_q;
        if (stall && !hold && !flush && scnt_q != CNT_MAX)
            scnt_d = scnt_q + CNT_W'(1);
        if (flush && fcnt_q != CNT_MAX)
            fcnt_d = fcnt_q + CNT_W'(1);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            valid_q <= 1'b0;
            rd_q    <= '0;
            ir_q    <= '0;
            pc_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            ctrl_q  <= CTRL_BUBBLE;
            scnt_q  <= '0;
            fcnt_q  <= '0;
        end else begin
            valid_q <= valid_d;
            rd_q    <= rd_d;
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            ctrl_q  <= ctrl_d;
            scnt_q  <= scnt_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_rd        = rd_q;
    assign ex_ir        = ir_q;
    assign ex_pc        = pc_q;
    assign ex_rs1_data  = rs1_q;
    assign ex_rs2_data  = rs2_q;
    assign ex_jump      = ctrl_q.jump;
    assign ex_branch    = ctrl_q.branch;
    assign ex_regWrite  = ctrl_q.regWrite;
    assign ex_memWE2    = ctrl_q.memWE2;
    assign ex_memRDEN2  = ctrl_q.memRDEN2;
    assign ex_alu_fun   = ctrl_q.alu_fun;
    assign ex_alu_srca  = ctrl_q.alu_srca;
    assign ex_alu_srcb  = ctrl_q.alu_srcb;
    assign ex_rf_wr_sel = ctrl_q.rf_wr_sel;
    assign stall_cnt    = scnt_q;
    assign flush_cnt    = fcnt_q;

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- ID/EX pipeline register of the pipelined OTTER MCU, directly downstream of the control-unit decoder.
- Captures decoder control outputs, PC, instruction fields and register-file read data every cycle.
- Detects load-use hazards against the instruction it currently holds, and requests an upstream stall by inserting a bubble.
- Accepts flush from branch/jump resolution and a global hold from memory wait states; keeps saturating stall/flush counters.

Parameters:
- XLEN, 32, datapath width of PC and operand registers.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_ir  in  32  instruction word (opcode, rs1, rs2, rd fields used).
- id_pc  in  XLEN  PC of the ID instruction.
- id_rs1_data, id_rs2_data  in  XLEN each  register-file read data.
- id_jump, id_branch, id_regWrite, id_memWE2, id_memRDEN2  in  1 each  decoder controls.
- id_alu_fun  in  4; id_alu_srca  in  2; id_alu_srcb  in  3; id_rf_wr_sel  in  2  decoder selects.
- flush  in  1  EX redirect (taken branch/jump): kill the instruction entering EX.
- hold  in  1  global freeze (memory wait).
- ex_* outputs  out  same widths as the id_* inputs, plus ex_valid (1) and ex_rd (5): registered copies.
- stall  out  1  combinational load-use stall to the PC and IF/ID register.
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Behaviour:
- Reset (RST_N=0, async): all ex_* outputs, ex_valid, ex_rd and both counters go to 0, so EX holds a NOP. The stall output is then 0 because ex_valid=0.
- Load detection: the EX instruction is a load when ex_valid & ex_memRDEN2 & ~ex_memWE2. Stores assert both RDEN2 and WE2 and are not loads.
- rs1 usage: rs1 is used unless the opcode is 0110111 (lui), 0010111 (auipc) or 1101111 (jal).
- rs2 usage: rs2 is used only for opcodes 0110011, 0100011 and 1100011.
- stall = id_valid & EX is a load & ex_rd != 0 & ((rs1 used & rs1==ex_rd) | (rs2 used & rs2==ex_rd)). The equation is purely combinational.
- Per-edge update, in priority order:
  1. flush=1: load a bubble, regardless of hold or stall.
  2. Else hold=1: all registers keep their value; counters do not count.
  3. Else stall=1: load a bubble.
  4. Else: capture all id_* inputs; ex_valid <= id_valid; ex_rd <= id_ir[11:7].
- Bubble definition:
  - ex_valid, ex_regWrite, ex_memWE2, ex_memRDEN2, ex_jump and ex_branch = 0.
  - ex_rd = 0.
  - All other ex_* fields = 0.
- Invalid capture: when id_valid=0 on a normal capture, the five side-effect controls are forced to 0, exactly as for a bubble.
- Latency: 1 cycle from id_* to ex_*.
- Stall clearing: a stall lasts exactly 1 cycle for a single load-use pair. After the bubble, ex_valid=0, so stall deasserts and the held ID instruction enters EX on the next edge.
- stall_cnt: increments on every edge where stall=1 & hold=0 & flush=0.
- flush_cnt: increments on every edge with flush=1.
- Counter saturation: both counters saturate at 2^CNT_W-1 with no wrap.
- Reset mid-stall or mid-hold: the async clear wins immediately; the pipeline restarts from a NOP.
- x0: a destination of x0 never causes a stall.

Decomposition:
- Package otter_pkg holds:
  - opcode constants (OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR);
  - a packed struct ctrl_t bundling jump, branch, regWrite, memWE2, memRDEN2, alu_fun, alu_srca, alu_srcb and rf_wr_sel;
  - a CTRL_BUBBLE constant with all fields 0.
- Sub-module hazard_unit: combinational load-use detection (rs-usage decode plus compares), producing stall.

Test Plan:
- Reset: hold RST_N=0 with random inputs, then release. Required: all ex_* = 0, stall=0, counters=0, both during and after reset.
- Normal flow: add x3,x1,x2 (ir 0x002081B3), pc=0x100, rs1=5, rs2=7. Required: next cycle ex_alu_fun=0000, ex_rf_wr_sel=11, ex_regWrite=1, ex_rd=3, ex_pc=0x100.
- Load-use: lw x5,0(x1) in EX, then add x6,x5,x2 in ID.
  - Required: stall=1 for 1 cycle; the bubble has ex_valid=0 and ex_regWrite=0; stall_cnt=1.
  - Required: the following cycle the add is captured with ex_rd=6.
- No false stall:
  - sw in EX with a matching rs: stall=0.
  - lw x0 in EX: stall=0.
  - lui in ID while a lw to x5 is in EX, with ir[19:15]=5: stall=0.
- Flush priority: flush=1 together with hold=1 and stall=1. Required: a bubble is loaded; flush_cnt increments by 1; stall_cnt is unchanged.
- Hold and saturation:
  - hold=1 for 3 cycles: ex_* remain frozen.
  - With CNT_W=2, 5 stall events: stall_cnt stops at 3.
